// File: rtl/sccb_config_sequencer_if.sv
// ---------------------------------------------------------------------------
// sccb_config_sequencer_if
//
// Bundles the command-ROM port and the write handshake toward the SCCB/I2C
// sender.
//
//   rom_addr  sequencer -> ROM     command ROM address
//   rom_data  ROM -> sequencer     {register, value}, one cycle after rom_addr
//   send      sequencer -> sender  write request, held until taken
//   taken     sender -> sequencer  single-cycle acceptance pulse
//   id        sequencer -> sender  SCCB write address (constant)
//   reg_i2c   sequencer -> sender  register address of the current write
//   value     sequencer -> sender  data of the current write
//
// Modports: master = sequencer side, slave = ROM/sender side.
// ---------------------------------------------------------------------------
interface sccb_config_sequencer_if #(
    parameter int ROM_AW = 8
);
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              send;
    logic              taken;
    logic [7:0]        id;
    logic [7:0]        reg_i2c;
    logic [7:0]        value;

    modport master (
        output rom_addr, send, id, reg_i2c, value,
        input  rom_data, taken
    );

    modport slave (
        input  rom_addr, send, id, reg_i2c, value,
        output rom_data, taken
    );
endinterface

// File: rtl/sccb_config_sequencer.sv
// ---------------------------------------------------------------------------
// sccb_config_sequencer
//
// Walks a command ROM of {register, value} words and issues one SCCB write
// per word through the sender handshake (send held until taken). Runs once
// after reset (after a power-up wait) and again on every start pulse seen
// while idle (DONE or ERROR).
//
// Reserved ROM words:
//   16'hFFFF  end of table
//   16'hFFF0  inline delay of DELAY_CYCLES
// The table also ends after the last ROM address is processed; rom_addr then
// holds at its maximum instead of wrapping.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       restart pulse, honoured only in DONE/ERROR
//   bus         ROM + sender handshake (sccb_config_sequencer_if.master)
//   busy        high while the sequence is running
//   done        high once the table has been completed
//   error       watchdog timeout flag (always 0 without CFG_TIMEOUT_EN)
//   cmd_count   writes accepted in the current run (wraps at ROM_AW bits)
//
// Optional feature macro: CFG_TIMEOUT_EN
//   Defined:   a watchdog aborts SEND to ERROR after TIMEOUT_CYCLES without
//              taken; taken in the expiry cycle still wins.
//   Undefined: SEND waits for taken indefinitely; ERROR is unreachable.
//
// Counter parameters are 24 bits; a value of 0 behaves as a 1-cycle wait.
// ---------------------------------------------------------------------------
module sccb_config_sequencer #(
    parameter logic [7:0]  DEV_ID         = 8'h42,
    parameter int          ROM_AW         = 8,
    parameter logic [23:0] POWERUP_CYCLES = 24'd1_000_000,
    parameter logic [23:0] DELAY_CYCLES   = 24'd1_000_000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd100_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    sccb_config_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ROM_AW-1:0]      cmd_count
);

    localparam logic [15:0] END_WORD   = 16'hFFFF;
    localparam logic [15:0] DELAY_WORD = 16'hFFF0;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state, state_nx;
    logic [ROM_AW-1:0]  addr, addr_nx;
    logic               send_r, send_nx;
    logic [7:0]         reg_r, reg_nx;
    logic [7:0]         val_r, val_nx;
    logic [23:0]        cnt, cnt_nx;
    logic [ROM_AW-1:0]  cmds, cmds_nx;
    logic               busy_r, busy_nx;
    logic               done_r, done_nx;
    logic               err_r, err_nx;
    // Set when the delay being timed came from the last ROM address, so the
    // delay exits to DONE instead of fetching (rom_addr no longer tells us,
    // because a delay at max-1 also leaves rom_addr at max).
    logic               at_end, at_end_nx;

    logic [23:0]        lim;
    logic               cnt_last;
    logic               addr_max;

    // One shared 24-bit counter times power-up, delay and the SEND watchdog;
    // the limit follows the state that is currently using it.
    always_comb begin
        lim = 24'd0;
        case (state)
            S_PWRUP: lim = POWERUP_CYCLES;
            S_DELAY: lim = DELAY_CYCLES;
            S_SEND:  lim = TIMEOUT_CYCLES;
            default: lim = 24'd0;
        endcase
    end

    // Counter starts at 0 on entry, so the wait lasts max(lim,1) cycles.
    assign cnt_last = (lim == 24'd0) || (cnt == lim - 24'd1);
    assign addr_max = &addr;

    // -----------------------------------------------------------------------
    // State / output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_PWRUP;
            addr   <= '0;
            send_r <= 1'b0;
            reg_r  <= 8'd0;
            val_r  <= 8'd0;
            cnt    <= 24'd0;
            cmds   <= '0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            at_end <= 1'b0;
        end else begin
            state  <= state_nx;
            addr   <= addr_nx;
            send_r <= send_nx;
            reg_r  <= reg_nx;
            val_r  <= val_nx;
            cnt    <= cnt_nx;
            cmds   <= cmds_nx;
            busy_r <= busy_nx;
            done_r <= done_nx;
            err_r  <= err_nx;
            at_end <= at_end_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx  = state;
        addr_nx   = addr;
        send_nx   = send_r;
        reg_nx    = reg_r;
        val_nx    = val_r;
        cnt_nx    = cnt;
        cmds_nx   = cmds;
        busy_nx   = busy_r;
        done_nx   = done_r;
        err_nx    = err_r;
        at_end_nx = at_end;

        case (state)
            S_PWRUP: begin
                if (cnt_last) state_nx = S_FETCH;
                else          cnt_nx   = cnt + 24'd1;
            end

            // rom_addr has been stable since entry; the ROM registers it at
            // the end of this cycle so rom_data is valid in DECODE.
            S_FETCH: state_nx = S_DECODE;

            S_DECODE: begin
                if (bus.rom_data == END_WORD) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = S_DONE;
                end else if (bus.rom_data == DELAY_WORD) begin
                    cnt_nx   = 24'd0;
                    state_nx = S_DELAY;
                    if (addr_max) at_end_nx = 1'b1;
                    else          addr_nx   = addr + ROM_AW'(1);
                end else begin
                    reg_nx   = bus.rom_data[15:8];
                    val_nx   = bus.rom_data[7:0];
                    send_nx  = 1'b1;
                    cnt_nx   = 24'd0;
                    state_nx = S_SEND;
                end
            end

            S_SEND: begin
                // taken is checked first so it wins over a watchdog expiry
                // in the same cycle.
                if (bus.taken) begin
                    send_nx = 1'b0;
                    cmds_nx = cmds + ROM_AW'(1);
                    if (addr_max) begin
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        addr_nx  = addr + ROM_AW'(1);
                        state_nx = S_FETCH;
                    end
                end
`ifdef CFG_TIMEOUT_EN
                else if (cnt_last) begin
                    send_nx  = 1'b0;
                    err_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = S_ERROR;
                end else begin
                    cnt_nx = cnt + 24'd1;
                end
`endif
            end

            S_DELAY: begin
                if (cnt_last) begin
                    if (at_end) begin
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_FETCH;
                    end
                end else begin
                    cnt_nx = cnt + 24'd1;
                end
            end

            // Restart skips PWRUP; reg_i2c/value keep the last write.
            S_DONE, S_ERROR: begin
                if (start) begin
                    addr_nx   = '0;
                    cmds_nx   = '0;
                    done_nx   = 1'b0;
                    err_nx    = 1'b0;
                    busy_nx   = 1'b1;
                    at_end_nx = 1'b0;
                    state_nx  = S_FETCH;
                end
            end

            default: state_nx = S_PWRUP;
        endcase
    end

    assign bus.rom_addr = addr;
    assign bus.send     = send_r;
    assign bus.id       = DEV_ID;
    assign bus.reg_i2c  = reg_r;
    assign bus.value    = val_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = err_r;
    assign cmd_count    = cmds;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sccb_config_sequencer
//
// The stimulus process is also the reference model: it walks the ROM table
// entry by entry, decides the sender's taken latency, sprinkles ignored
// start/taken pulses, and after every clock edge sets the outputs the block
// must show. A negedge process compares the DUT against those expectations
// every cycle; a few literal expectations pin whole scenarios.
// ---------------------------------------------------------------------------
module tb_sccb_config_sequencer;

    localparam int AW = 2;
    localparam int P  = 10;   // power-up cycles
    localparam int D  = 20;   // delay cycles
    localparam int T  = 8;    // watchdog cycles

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, error;
    logic [AW-1:0] cmd_count;

    sccb_config_sequencer_if #(.ROM_AW(AW)) bus ();

    sccb_config_sequencer #(
        .DEV_ID         (8'h42),
        .ROM_AW         (AW),
        .POWERUP_CYCLES (24'd10),
        .DELAY_CYCLES   (24'd20),
        .TIMEOUT_CYCLES (24'd8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    // Command ROM with one cycle of read latency.
    logic [15:0] rom [4];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    // ---------------- checking ----------------
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    endtask

    // Model expectations
    logic [AW-1:0] e_addr, e_cnt;
    logic          e_send, e_busy, e_done, e_err;
    logic [7:0]    e_reg, e_val;
    bit            chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("send",      {31'd0, bus.send},        {31'd0, e_send});
            chk("reg_value", {16'd0, bus.reg_i2c, bus.value}, {16'd0, e_reg, e_val});
            chk("status",    {29'd0, busy, done, error}, {29'd0, e_busy, e_done, e_err});
            chk("rom_addr",  32'(bus.rom_addr),        32'(e_addr));
            chk("cmd_count", 32'(cmd_count),           32'(e_cnt));
            chk("id",        32'(bus.id),              32'h42);
        end
    end

    // Observer of the DUT's write stream for the literal scenario checks.
    logic [15:0] dut_log[$];
    int   ncyc = 0, fall_cyc = 0, gap = 0, hi_len = 0, last_hi = 0;
    logic prev_send = 1'b0;

    always @(negedge clk) begin
        ncyc      <= ncyc + 1;
        prev_send <= bus.send;
        if (bus.send === 1'b1) hi_len <= hi_len + 1;
        if (bus.send === 1'b1 && prev_send === 1'b0) begin
            dut_log.push_back({bus.reg_i2c, bus.value});
            gap <= ncyc - fall_cyc;
        end
        if (bus.send === 1'b0 && prev_send === 1'b1) begin
            fall_cyc <= ncyc;
            last_hi  <= hi_len;
            hi_len   <= 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- model / stimulus ----------------
    int lat_mode   = -1;  // -1: random taken latency 0..6, else fixed
    bit abort_mode = 1'b0;

    function automatic bit rnd(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic cyc(input bit tk, input bit st);
        bus.taken = tk;
        start     = st;
        @(posedge clk);
        #1;
        bus.taken = 1'b0;
        start     = 1'b0;
    endtask

    // A cycle where both start and taken must be ignored.
    task automatic noise();
        cyc(rnd(25), rnd(25));
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(rnd(25), 1'b0);
    endtask

    task automatic set_reset_exp();
        e_addr = '0; e_cnt = '0; e_send = 1'b0; e_reg = 8'd0; e_val = 8'd0;
        e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_send",  {31'd0, bus.send}, 32'd0);
        chk("async_busy",  {31'd0, busy},     32'd1);
        chk("async_addr",  32'(bus.rom_addr), 32'd0);
        chk("async_value", {24'd0, bus.value}, 32'd0);
        set_reset_exp();
        repeat (3) cyc(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Play one pass over the table, updating expectations edge by edge.
    task automatic run_table(input bit from_reset);
        int          a, lat;
        bit          last;
        logic [15:0] w;
        if (from_reset) repeat (P) noise();
        a = 0;
        forever begin
            noise();              // FETCH
            noise();              // DECODE, acted on at this edge
            w    = rom[a];
            last = (a == (1 << AW) - 1);
            if (w == 16'hFFFF) begin
                e_busy = 1'b0; e_done = 1'b1;
                return;
            end
            if (w == 16'hFFF0) begin
                if (!last) a++;
                e_addr = AW'(a);
                repeat (D) noise();
                if (last) begin
                    e_busy = 1'b0; e_done = 1'b1;
                    return;
                end
            end else begin
                e_send = 1'b1; e_reg = w[15:8]; e_val = w[7:0];
                lat = (lat_mode < 0) ? int'($urandom_range(6)) : lat_mode;
                for (int k = 0; k < 1000; k++) begin
                    if (abort_mode && k == 2) begin
                        do_reset();
                        return;
                    end
                    if (k == lat) begin
                        cyc(1'b1, rnd(25));
                        e_send = 1'b0;
                        e_cnt++;
                        if (last) begin
                            e_busy = 1'b0; e_done = 1'b1;
                            return;
                        end
                        a++;
                        e_addr = AW'(a);
                        break;
                    end
                    cyc(1'b0, rnd(25));
`ifdef CFG_TIMEOUT_EN
                    if (k + 1 == T) begin
                        e_send = 1'b0; e_err = 1'b1; e_busy = 1'b0;
                        return;
                    end
`endif
                end
            end
        end
    endtask

    task automatic restart();
        idle(3);
        cyc(rnd(25), 1'b1);
        e_addr = '0; e_cnt = '0; e_done = 1'b0; e_err = 1'b0; e_busy = 1'b1;
        run_table(1'b0);
    endtask

    initial begin
        int r;
        set_reset_exp();
        bus.taken = 1'b0;
        rom = '{16'h1280, 16'h1204, 16'hFFFF, 16'h0000};
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        cyc(1'b0, 1'b0);
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_id",   32'(bus.id),   32'h42);
        rst_n = 1'b1;

        // Basic table after power-up, taken three cycles after send.
        lat_mode = 3;
        dut_log.delete();
        run_table(1'b1);
        idle(4);
        chk("t1_writes", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) begin
            chk("t1_w0", 32'(dut_log[0]), 32'h1280);
            chk("t1_w1", 32'(dut_log[1]), 32'h1204);
        end
        chk("t1_cmd_count", 32'(cmd_count), 32'd2);
        chk("t1_done_busy", {30'd0, done, busy}, 32'b10);

        // Restart repeats the identical sequence without power-up.
        dut_log.delete();
        restart();
        idle(2);
        chk("t1b_writes", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) chk("t1b_w1", 32'(dut_log[1]), 32'h1204);

        // Inline delay: FETCH+DECODE+20 DELAY+FETCH+DECODE between writes.
        rom = '{16'h1100, 16'hFFF0, 16'h3A04, 16'hFFFF};
        lat_mode = 1;
        dut_log.delete();
        restart();
        idle(2);
        chk("t2_gap", 32'(gap), 32'd24);
        chk("t2_cmd_count", 32'(cmd_count), 32'd2);
        if (dut_log.size() == 2) chk("t2_w1", 32'(dut_log[1]), 32'h3A04);
        else chk("t2_writes", 32'(dut_log.size()), 32'd2);

        // Long hold in SEND (watchdog expiry when the timeout is built in).
        rom = '{16'h5511, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        lat_mode = 50;
        restart();
        idle(2);
`ifdef CFG_TIMEOUT_EN
        chk("t3_send_cycles", 32'(last_hi), 32'(T));
        chk("t3_error", {29'd0, error, busy, bus.send}, 32'b100);
        lat_mode = 2;
        restart();
        chk("t3_error_cleared", {30'd0, error, done}, 32'b01);
`else
        chk("t3_send_cycles", 32'(last_hi), 32'd51);
        chk("t3_error", {31'd0, error}, 32'd0);
`endif

        // Table exhaustion without an end marker.
        rom = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        lat_mode = -1;
        dut_log.delete();
        restart();
        idle(2);
        chk("t4_writes", 32'(dut_log.size()), 32'd4);
        chk("t4_rom_addr", 32'(bus.rom_addr), 32'd3);
        chk("t4_cmd_count_wrap", 32'(cmd_count), 32'd0);

        // Delay marker at the last address also ends the table.
        rom = '{16'h0707, 16'h0808, 16'h0909, 16'hFFF0};
        restart();
        chk("t4b_rom_addr", 32'(bus.rom_addr), 32'd3);
        chk("t4b_cmd_count", 32'(cmd_count), 32'd3);

        // Reset while send is high, then a full run from power-up.
        rom = '{16'h2222, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        lat_mode   = 10;
        abort_mode = 1'b1;
        restart();
        abort_mode = 1'b0;
        lat_mode   = -1;
        run_table(1'b1);
        chk("t5_cmd_count", 32'(cmd_count), 32'd1);

        // Random tables.
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 4; i++) begin
                r = int'($urandom_range(99));
                if (r < 12)      rom[i] = 16'hFFFF;
                else if (r < 27) rom[i] = 16'hFFF0;
                else             rom[i] = {8'($urandom_range(254)), 8'($urandom)};
            end
            restart();
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
